// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS core. Sequences a shared memory, ALU, PC and register
// file through fetch/decode/execute/memory/writeback steps for R-type, lw, sw, beq, addi, ori, j.
// Memory steps wait on mem_ready_i with an optional timeout; bad opcodes and timeouts trap.
//
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   opcode_i          IR[31:26], valid from DECODE onward
//   mem_ready_i       memory handshake, access completes in the cycle it is sampled high
//   pc_write_o        unconditional PC load
//   pc_write_cond_o   PC load if alu_zero (ANDed externally)
//   pc_source_o       00 ALU result, 01 ALUOut, 10 jump target
//   iord_o            memory address select: 0 PC, 1 ALUOut
//   mem_read_o        memory read strobe
//   mem_write_o       memory write strobe
//   ir_write_o        instruction register load
//   reg_dst_o         write register: 0 rt, 1 rd
//   mem_to_reg_o      write data: 0 ALUOut, 1 MDR
//   reg_write_o       register file write enable
//   alu_src_a_o       0 PC, 1 A register
//   alu_src_b_o       00 B, 01 const 4, 10 imm, 11 imm<<2
//   zero_ext_o        immediate zero-extended (ori)
//   alu_op_o          00 add, 01 sub, 10 funct, 11 or-immediate
//   state_o           current state encoding (debug)
//   instr_done_o      one-cycle pulse when an instruction retires
//   instr_count_o     retired instruction count, wraps
//   illegal_op_o      sticky: trapped on unsupported opcode
//   bus_error_o       sticky: trapped on memory timeout
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             pc_write_cond_o,
    output logic [1:0]       pc_source_o,
    output logic             iord_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             ir_write_o,
    output logic             reg_dst_o,
    output logic             mem_to_reg_o,
    output logic             reg_write_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic             zero_ext_o,
    output logic [1:0]       alu_op_o,
    output logic [3:0]       state_o,
    output logic             instr_done_o,
    output logic [CNT_W-1:0] instr_count_o,
    output logic             illegal_op_o,
    output logic             bus_error_o
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAddr  = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecute  = 4'd6,
        StAluWb    = 4'd7,
        StBranch   = 4'd8,
        StAddiExec = 4'd9,
        StOriExec  = 4'd10,
        StImmWb    = 4'd11,
        StJump     = 4'd12,
        StTrap     = 4'd15
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;

    // Counter never exceeds MEM_TIMEOUT-1, so this many bits suffice.
    localparam int unsigned WaitW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WaitW-1:0] WaitMax = WaitW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    state_e             state_q, state_d;
    logic [WaitW-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               illegal_q, illegal_d;
    logic               bus_err_q, bus_err_d;
    logic               timeout;
    logic               wait_state;

    assign wait_state = (state_q == StFetch) || (state_q == StMemRead) ||
                        (state_q == StMemWrite);
    assign timeout    = (MEM_TIMEOUT != 0) && wait_state && !mem_ready_i && (wait_q == WaitMax);

    always_comb begin
        state_d         = state_q;
        illegal_d       = illegal_q;
        bus_err_d       = bus_err_q;
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        pc_source_o     = 2'b00;
        iord_o          = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        ir_write_o      = 1'b0;
        reg_dst_o       = 1'b0;
        mem_to_reg_o    = 1'b0;
        reg_write_o     = 1'b0;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = 2'b00;
        zero_ext_o      = 1'b0;
        alu_op_o        = 2'b00;
        instr_done_o    = 1'b0;

        // Outputs stay all-zero while reset is held, even though state already reads FETCH.
        if (!reset) begin
            unique case (state_q)
                StFetch: begin
                    mem_read_o  = 1'b1;
                    alu_src_b_o = 2'b01;
                    if (mem_ready_i) begin
                        ir_write_o = 1'b1;
                        pc_write_o = 1'b1;
                        state_d    = StDecode;
                    end else if (timeout) begin
                        state_d   = StTrap;
                        bus_err_d = 1'b1;
                    end
                end
                StDecode: begin
                    alu_src_b_o = 2'b11;
                    unique case (opcode_i)
                        OpLw, OpSw: state_d = StMemAddr;
                        OpRtype:    state_d = StExecute;
                        OpBeq:      state_d = StBranch;
                        OpAddi:     state_d = StAddiExec;
                        OpOri:      state_d = StOriExec;
                        OpJ:        state_d = StJump;
                        default: begin
                            state_d   = StTrap;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
                StMemAddr: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'b10;
                    state_d     = (opcode_i == OpLw) ? StMemRead : StMemWrite;
                end
                StMemRead: begin
                    mem_read_o = 1'b1;
                    iord_o     = 1'b1;
                    if (mem_ready_i) begin
                        state_d = StMemWb;
                    end else if (timeout) begin
                        state_d   = StTrap;
                        bus_err_d = 1'b1;
                    end
                end
                StMemWb: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = 1'b1;
                    instr_done_o = 1'b1;
                    state_d      = StFetch;
                end
                StMemWrite: begin
                    mem_write_o = 1'b1;
                    iord_o      = 1'b1;
                    if (mem_ready_i) begin
                        instr_done_o = 1'b1;
                        state_d      = StFetch;
                    end else if (timeout) begin
                        state_d   = StTrap;
                        bus_err_d = 1'b1;
                    end
                end
                StExecute: begin
                    alu_src_a_o = 1'b1;
                    alu_op_o    = 2'b10;
                    state_d     = StAluWb;
                end
                StAluWb: begin
                    reg_write_o  = 1'b1;
                    reg_dst_o    = 1'b1;
                    instr_done_o = 1'b1;
                    state_d      = StFetch;
                end
                StBranch: begin
                    alu_src_a_o     = 1'b1;
                    alu_op_o        = 2'b01;
                    pc_write_cond_o = 1'b1;
                    pc_source_o     = 2'b01;
                    instr_done_o    = 1'b1;
                    state_d         = StFetch;
                end
                StAddiExec: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'b10;
                    state_d     = StImmWb;
                end
                StOriExec: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'b10;
                    zero_ext_o  = 1'b1;
                    alu_op_o    = 2'b11;
                    state_d     = StImmWb;
                end
                StImmWb: begin
                    reg_write_o  = 1'b1;
                    instr_done_o = 1'b1;
                    state_d      = StFetch;
                end
                StJump: begin
                    pc_write_o   = 1'b1;
                    pc_source_o  = 2'b10;
                    instr_done_o = 1'b1;
                    state_d      = StFetch;
                end
                default: state_d = StTrap;  // TRAP absorbs; unused encodings fall in
            endcase
        end
    end

    // Counter restarts whenever a wait state is (re)entered and only counts while held there.
    always_comb begin
        wait_d = '0;
        if (wait_state && (state_d == state_q)) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_comb begin
        count_d = count_q;
        if (instr_done_o) begin
            count_d = count_q + CntOne;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StFetch;
            wait_q    <= '0;
            count_q   <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign state_o       = state_q;
    assign instr_count_o = count_q;
    assign illegal_op_o  = illegal_q;
    assign bus_error_o   = bus_err_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    localparam logic [5:0] OpR    = 6'b000000;
    localparam logic [5:0] OpJ    = 6'b000010;
    localparam logic [5:0] OpBeq  = 6'b000100;
    localparam logic [5:0] OpOri  = 6'b001101;
    localparam logic [5:0] OpLw   = 6'b100011;
    localparam logic [5:0] OpSw   = 6'b101011;
    localparam logic [5:0] OpBad  = 6'b111111;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, zero_ext;
    logic [1:0] pc_source, alu_src_b, alu_op;
    logic [3:0] state;
    logic       instr_done, illegal_op, bus_error;
    logic [1:0] instr_count;

    int errors = 0;
    int checks = 0;

    multicycle_control #(
        .MEM_TIMEOUT(4),
        .CNT_W      (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .opcode_i       (opcode),
        .mem_ready_i    (mem_ready),
        .pc_write_o     (pc_write),
        .pc_write_cond_o(pc_write_cond),
        .pc_source_o    (pc_source),
        .iord_o         (iord),
        .mem_read_o     (mem_read),
        .mem_write_o    (mem_write),
        .ir_write_o     (ir_write),
        .reg_dst_o      (reg_dst),
        .mem_to_reg_o   (mem_to_reg),
        .reg_write_o    (reg_write),
        .alu_src_a_o    (alu_src_a),
        .alu_src_b_o    (alu_src_b),
        .zero_ext_o     (zero_ext),
        .alu_op_o       (alu_op),
        .state_o        (state),
        .instr_done_o   (instr_done),
        .instr_count_o  (instr_count),
        .illegal_op_o   (illegal_op),
        .bus_error_o    (bus_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        opcode    = OpR;
        mem_ready = 1'b0;
        #2;
        chk("rst_state", state, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_count", instr_count, 0);
        chk("rst_flags", {illegal_op, bus_error}, 0);
        tick();
        reset = 1'b0;
        #1;
        chk("fetch_mem_read", mem_read, 1);
        chk("fetch_alu_b", alu_src_b, 1);

        // lw, mem_ready tied high: 0,1,2,3,4 then 0
        mem_ready = 1'b1;
        opcode    = OpLw;
        #1;
        chk("lw_fetch_irw_pcw", {ir_write, pc_write}, 2'b11);
        tick();
        chk("lw_decode", state, 1);
        chk("lw_decode_b", alu_src_b, 3);
        tick();
        chk("lw_memaddr", {state, alu_src_a, alu_src_b}, {4'd2, 1'b1, 2'b10});
        chk("lw_memaddr_rw", reg_write, 0);
        tick();
        chk("lw_memread", {state, mem_read, iord}, {4'd3, 2'b11});
        chk("lw_memread_rw", {reg_write, mem_to_reg}, 0);
        tick();
        chk("lw_memwb", {state, reg_write, mem_to_reg, reg_dst, instr_done}, {4'd4, 4'b1101});
        chk("lw_count_before", instr_count, 0);
        tick();
        chk("lw_back_fetch", state, 0);
        chk("lw_count_after", instr_count, 1);

        // beq: 3 cycles
        opcode = OpBeq;
        tick();
        tick();
        chk("beq_state", state, 8);
        chk("beq_ctl", {pc_write_cond, pc_source, alu_op, pc_write}, {1'b1, 2'b01, 2'b01, 1'b0});
        chk("beq_done", instr_done, 1);
        tick();
        chk("beq_fetch", {state, instr_count}, {4'd0, 2'd2});

        // j: 3 cycles
        opcode = OpJ;
        tick();
        tick();
        chk("j_state", state, 12);
        chk("j_ctl", {pc_write, pc_source, pc_write_cond}, {1'b1, 2'b10, 1'b0});
        tick();
        chk("j_fetch", {state, instr_count}, {4'd0, 2'd3});

        // R-type: count wraps 3 -> 0 at CNT_W=2
        opcode = OpR;
        tick();
        tick();
        chk("r_exec", {state, alu_src_a, alu_src_b, alu_op}, {4'd6, 1'b1, 2'b00, 2'b10});
        tick();
        chk("r_aluwb", {state, reg_write, reg_dst, mem_to_reg}, {4'd7, 3'b110});
        tick();
        chk("r_wrap", {state, instr_count}, {4'd0, 2'd0});

        // ori
        opcode = OpOri;
        tick();
        tick();
        chk("ori_exec", {state, zero_ext, alu_op, alu_src_b}, {4'd10, 1'b1, 2'b11, 2'b10});
        tick();
        chk("ori_immwb", {state, reg_write, reg_dst}, {4'd11, 2'b10});
        tick();
        chk("ori_count", instr_count, 1);

        // Fetch stall: 3 cycles without ready, then ready (counter at MEM_TIMEOUT-1, ready wins)
        mem_ready = 1'b0;
        opcode    = OpSw;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_hold", {state, ir_write, pc_write, mem_read}, {4'd0, 3'b001});
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk("stall_release", {state, ir_write, pc_write}, {4'd0, 2'b11});
        tick();
        chk("stall_decode", {state, bus_error}, {4'd1, 1'b0});
        tick();
        tick();
        chk("sw_memwrite", {state, mem_write, iord, instr_done}, {4'd5, 3'b111});
        tick();
        chk("sw_retire", {state, instr_count}, {4'd0, 2'd2});

        // sw timeout in MEM_WRITE: trap after 4 cycles
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("to_wait", {state, mem_write, instr_done}, {4'd5, 2'b10});
            tick();
        end
        chk("to_trap", {state, bus_error, illegal_op}, {4'd15, 2'b10});
        chk("to_strobes", {mem_write, mem_read, pc_write, reg_write}, 0);
        mem_ready = 1'b1;
        tick();
        tick();
        chk("to_held", {state, bus_error, instr_count}, {4'd15, 1'b1, 2'd2});

        reset = 1'b1;
        #1;
        chk("to_reset", {state, bus_error, illegal_op, instr_count}, 0);
        tick();
        reset = 1'b0;

        // Illegal opcode
        opcode = OpBad;
        tick();
        tick();
        chk("ill_trap", {state, illegal_op, bus_error}, {4'd15, 2'b10});
        tick();
        chk("ill_held", {state, mem_read}, {4'd15, 1'b0});
        reset = 1'b1;
        #1;
        chk("ill_reset", {state, illegal_op, bus_error}, 0);
        tick();
        reset = 1'b0;

        // Async reset in the middle of MEM_WRITE
        opcode    = OpSw;
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        chk("ar_memwrite", {state, mem_write}, {4'd5, 1'b1});
        #2;
        reset = 1'b1;
        #1;
        chk("ar_immediate", {state, mem_write, iord, reg_write, pc_write}, 0);
        tick();
        reset     = 1'b0;
        mem_ready = 1'b1;

        // Five retirements wrap the 2-bit counter to 1
        opcode = OpJ;
        for (int i = 0; i < 5; i++) begin
            tick();
            tick();
            tick();
        end
        chk("wrap5", {state, instr_count}, {4'd0, 2'd1});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
